// File: rtl/spi_read_ctrl.sv
// -----------------------------------------------------------------------------
// spi_read_ctrl
//
// SPI read master for the ILI9341 panel. Shifts out one command byte with DC
// low, inserts a fixed number of dummy SCK periods, then clocks in byteCount
// data bytes from the panel SDO line. Each received byte is presented on
// dataOut together with a one-cycle dataValid strobe. SCK is derived from inClk
// by a half-period counter, so the whole block runs in a single clock domain.
//
// Parameters
//   div        inClk cycles per SCK period (even, >= 2); half period H = div/2
//   bitSize    width of the half-period counter
//   dummyBits  SCK periods between command and data phase (0..7)
//
// Ports
//   inClk      system clock, all logic on the rising edge
//   nReset     asynchronous active-low reset
//   start      single-cycle request, only honoured in IDLE
//   cmd        command byte, latched on an accepted start
//   byteCount  number of data bytes to read (0..7), latched on an accepted start
//   busy       high while a transaction is in progress
//   done       one-cycle pulse at transaction end
//   dataOut    last received byte, held until the next byte completes
//   dataValid  one-cycle pulse when dataOut updates
//   spiCs      chip select, active low
//   spiDc      0 during the command byte, 1 otherwise
//   spiSck     serial clock, idle low (mode 0)
//   spiMosi    command data, MSB first, changes on SCK falling edges
//   spiMiso    panel SDO, sampled on SCK rising edges
// -----------------------------------------------------------------------------
module spi_read_ctrl #(
    parameter int div       = 4,
    parameter int bitSize   = 16,
    parameter int dummyBits = 1
) (
    input  logic       inClk,
    input  logic       nReset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [2:0] byteCount,
    output logic       busy,
    output logic       done,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       spiCs,
    output logic       spiDc,
    output logic       spiSck,
    output logic       spiMosi,
    input  logic       spiMiso
);

    localparam logic [bitSize-1:0] HALF_LAST = bitSize'(div / 2 - 1);
    localparam logic [5:0]         DUMMY_LEN = 6'(dummyBits);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        DUMMY,
        READ,
        CS_HOLD
    } state_t;

    state_t             state_reg, state_next, next_phase;
    logic [bitSize-1:0] cnt_reg;
    logic [5:0]         per_cnt_reg;   // SCK periods completed in the current phase
    logic [6:0]         tx_reg;        // remaining command bits after the MSB
    logic [6:0]         shift_reg;     // received bits of the byte in flight
    logic [2:0]         count_reg;
    logic [7:0]         data_reg;
    logic               sck_reg, cs_reg, dc_reg, mosi_reg;
    logic               busy_reg, done_reg, valid_reg;

    logic               tick, accept, do_rise, do_fall, finish, read_rise;
    logic [5:0]         phase_len;

    // One tick per elapsed half period while a transaction is running.
    assign tick = busy_reg && (cnt_reg == HALF_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge inClk or negedge nReset) begin
        if (!nReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and SCK edge decisions
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        next_phase = CS_HOLD;
        accept     = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        finish     = 1'b0;

        case (state_reg)
            DUMMY:   phase_len = DUMMY_LEN;
            READ:    phase_len = {count_reg, 3'b000};
            default: phase_len = 6'd8;
        endcase

        // Phase that follows once the current one has run its periods.
        if (state_reg == CMD && count_reg != 3'd0) begin
            next_phase = (DUMMY_LEN == 6'd0) ? READ : DUMMY;
        end else if (state_reg == DUMMY) begin
            next_phase = READ;
        end

        case (state_reg)
            IDLE: begin
                // The done cycle itself never accepts a new request.
                if (start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    do_rise    = 1'b1;
                    state_next = CMD;
                end
            end
            CMD, DUMMY, READ: begin
                if (tick) begin
                    if (sck_reg) begin
                        do_fall = 1'b1;
                    end else if (per_cnt_reg != phase_len) begin
                        do_rise = 1'b1;
                    end else begin
                        // The low half of the last period has elapsed: this
                        // tick is the first rise of the next phase, if any.
                        state_next = next_phase;
                        do_rise    = (next_phase != CS_HOLD);
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        read_rise = do_rise && (state_next == READ);
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge inClk or negedge nReset) begin
        if (!nReset) begin
            cnt_reg     <= '0;
            per_cnt_reg <= '0;
            tx_reg      <= '0;
            shift_reg   <= '0;
            count_reg   <= '0;
            data_reg    <= 8'h00;
            sck_reg     <= 1'b0;
            cs_reg      <= 1'b1;
            dc_reg      <= 1'b1;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;

            if (accept) begin
                tx_reg    <= cmd[6:0];
                count_reg <= byteCount;
                busy_reg  <= 1'b1;
                cs_reg    <= 1'b0;
                dc_reg    <= 1'b0;
                mosi_reg  <= cmd[7];
                sck_reg   <= 1'b0;
                cnt_reg   <= '0;
            end else if (busy_reg) begin
                cnt_reg <= tick ? '0 : cnt_reg + bitSize'(1);
            end

            if (state_next != state_reg) begin
                per_cnt_reg <= '0;
            end else if (do_fall) begin
                per_cnt_reg <= per_cnt_reg + 6'd1;
            end

            if (do_rise) begin
                sck_reg <= 1'b1;
            end
            if (do_fall) begin
                sck_reg <= 1'b0;
            end

            // Command bits advance on falling edges; the eighth fall ends the
            // command byte, so DC returns high and MOSI parks low.
            if (do_fall && state_reg == CMD) begin
                mosi_reg <= tx_reg[6];
                tx_reg   <= {tx_reg[5:0], 1'b0};
                if (per_cnt_reg[2:0] == 3'd7) begin
                    dc_reg   <= 1'b1;
                    mosi_reg <= 1'b0;
                end
            end

            // The entry rise into READ is always bit 7 of the first byte,
            // so only rises made from within READ can complete a byte.
            if (read_rise) begin
                shift_reg <= {shift_reg[5:0], spiMiso};
                if (state_reg == READ && per_cnt_reg[2:0] == 3'd7) begin
                    data_reg  <= {shift_reg, spiMiso};
                    valid_reg <= 1'b1;
                end
            end

            if (finish) begin
                cs_reg   <= 1'b1;
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign dataOut   = data_reg;
    assign dataValid = valid_reg;
    assign spiCs     = cs_reg;
    assign spiDc     = dc_reg;
    assign spiSck    = sck_reg;
    assign spiMosi   = mosi_reg;

endmodule

// File: tb/tb_spi_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_read_ctrl
//
// Directed bench for spi_read_ctrl. Instance a runs with div=4, dummyBits=1;
// instance b runs with div=2, dummyBits=1. Each instance has a small panel
// model that drives MISO after SCK falling edges and monitors that count SCK
// rises, busy/done/SCK-high cycles and collect every dataValid byte.
// -----------------------------------------------------------------------------
module tb_spi_read_ctrl;

    logic inClk  = 1'b0;
    logic nReset = 1'b0;

    always #5 inClk = ~inClk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instance a: div=4, dummyBits=1 ----------------
    logic       a_start = 1'b0;
    logic [7:0] a_cmd   = 8'h00;
    logic [2:0] a_count = 3'd0;
    logic       a_miso  = 1'b0;
    logic       a_busy, a_done, a_valid, a_cs, a_dc, a_sck, a_mosi;
    logic [7:0] a_data;

    spi_read_ctrl #(.div(4), .bitSize(16), .dummyBits(1)) u_dut_a (
        .inClk(inClk), .nReset(nReset), .start(a_start), .cmd(a_cmd),
        .byteCount(a_count), .busy(a_busy), .done(a_done), .dataOut(a_data),
        .dataValid(a_valid), .spiCs(a_cs), .spiDc(a_dc), .spiSck(a_sck),
        .spiMosi(a_mosi), .spiMiso(a_miso)
    );

    // ---------------- instance b: div=2, dummyBits=1 ----------------
    logic       b_start = 1'b0;
    logic [7:0] b_cmd   = 8'h00;
    logic [2:0] b_count = 3'd0;
    logic       b_miso  = 1'b0;
    logic       b_busy, b_done, b_valid, b_cs, b_dc, b_sck, b_mosi;
    logic [7:0] b_data;

    spi_read_ctrl #(.div(2), .bitSize(16), .dummyBits(1)) u_dut_b (
        .inClk(inClk), .nReset(nReset), .start(b_start), .cmd(b_cmd),
        .byteCount(b_count), .busy(b_busy), .done(b_done), .dataOut(b_data),
        .dataValid(b_valid), .spiCs(b_cs), .spiDc(b_dc), .spiSck(b_sck),
        .spiMosi(b_mosi), .spiMiso(b_miso)
    );

    // ---------------- monitors and panel model, instance a ----------------
    int         a_rises = 0, a_dclow = 0, a_falls = 0, a_fbase = 0;
    int         a_busyc = 0, a_donec = 0, a_highc = 0, a_nbits = 0;
    logic [7:0] a_mosi_sr = 8'h00;
    logic [7:0] a_rd [0:7];
    logic [7:0] a_vals [$];

    always @(posedge a_sck) begin
        a_rises++;
        if (!a_dc) begin
            a_dclow++;
            a_mosi_sr = {a_mosi_sr[6:0], a_mosi};
        end
    end

    always @(negedge a_cs) a_fbase = a_falls;

    // Read bits follow 8 command falls and 1 dummy fall.
    always @(negedge a_sck) begin : a_panel
        int idx;
        a_falls++;
        idx = a_falls - a_fbase - 9;
        if (idx >= 0 && idx < a_nbits) a_miso = a_rd[idx[5:3]][3'd7 - idx[2:0]];
    end

    always @(negedge inClk) begin
        if (a_busy === 1'b1) a_busyc++;
        if (a_done === 1'b1) a_donec++;
        if (a_busy === 1'b1 && a_sck === 1'b1) a_highc++;
        if (a_valid === 1'b1) a_vals.push_back(a_data);
    end

    // ---------------- monitors and panel model, instance b ----------------
    int         b_rises = 0, b_falls = 0, b_fbase = 0;
    int         b_busyc = 0, b_donec = 0, b_highc = 0, b_nbits = 0;
    logic [7:0] b_mosi_sr = 8'h00;
    logic [7:0] b_rd [0:7];
    logic [7:0] b_vals [$];

    always @(posedge b_sck) begin
        b_rises++;
        if (!b_dc) b_mosi_sr = {b_mosi_sr[6:0], b_mosi};
    end

    always @(negedge b_cs) b_fbase = b_falls;

    always @(negedge b_sck) begin : b_panel
        int idx;
        b_falls++;
        idx = b_falls - b_fbase - 9;
        if (idx >= 0 && idx < b_nbits) b_miso = b_rd[idx[5:3]][3'd7 - idx[2:0]];
    end

    always @(negedge inClk) begin
        if (b_busy === 1'b1) b_busyc++;
        if (b_done === 1'b1) b_donec++;
        if (b_busy === 1'b1 && b_sck === 1'b1) b_highc++;
        if (b_valid === 1'b1) b_vals.push_back(b_data);
    end

    // ---------------- baselines and helpers ----------------
    int a_r0, a_d0, a_bc0, a_dn0, a_h0, a_v0;
    int b_r0, b_bc0, b_dn0, b_h0, b_v0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap_a();
        a_r0 = a_rises; a_d0 = a_dclow; a_bc0 = a_busyc;
        a_dn0 = a_donec; a_h0 = a_highc; a_v0 = a_vals.size();
    endtask

    task automatic snap_b();
        b_r0 = b_rises; b_bc0 = b_busyc; b_dn0 = b_donec;
        b_h0 = b_highc; b_v0 = b_vals.size();
    endtask

    // Called at posedge+1; start is sampled on the following edge.
    task automatic run_a(input logic [7:0] c, input logic [2:0] n);
        a_cmd = c; a_count = n; a_start = 1'b1;
        @(posedge inClk); #1;
        a_start = 1'b0;
    endtask

    task automatic run_b(input logic [7:0] c, input logic [2:0] n);
        b_cmd = c; b_count = n; b_start = 1'b1;
        @(posedge inClk); #1;
        b_start = 1'b0;
    endtask

    task automatic wait_a(input int limit);
        for (int i = 0; i < limit && (a_donec - a_dn0) == 0; i++) begin
            @(posedge inClk); #1;
        end
        repeat (2) begin @(posedge inClk); #1; end
    endtask

    task automatic wait_b(input int limit);
        for (int i = 0; i < limit && (b_donec - b_dn0) == 0; i++) begin
            @(posedge inClk); #1;
        end
        repeat (2) begin @(posedge inClk); #1; end
    endtask

    task automatic chk_val_a(input string tag, input int k, input logic [7:0] exp);
        logic [7:0] v;
        v = (a_v0 + k < a_vals.size()) ? a_vals[a_v0 + k] : 8'hxx;
        chk(tag, 32'(v), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with start asserted: nothing may move.
        a_start = 1'b1; a_cmd = 8'hFF; a_count = 3'd7;
        b_start = 1'b1; b_cmd = 8'hFF; b_count = 3'd7;
        repeat (4) @(posedge inClk);
        #1;
        chk("rst_cs",    32'(a_cs), 32'd1);
        chk("rst_sck",   32'(a_sck), 32'd0);
        chk("rst_dc",    32'(a_dc), 32'd1);
        chk("rst_mosi",  32'(a_mosi), 32'd0);
        chk("rst_busy",  32'(a_busy), 32'd0);
        chk("rst_done",  32'(a_done), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data",  32'(a_data), 32'h00);
        chk("rst_rises", 32'(a_rises), 32'd0);
        chk("rst_b_cs",  32'(b_cs), 32'd1);
        a_start = 1'b0; b_start = 1'b0;
        @(posedge inClk); #1;
        nReset = 1'b1;
        repeat (2) begin @(posedge inClk); #1; end

        // Read ID: cmd 0x04, three bytes 00 93 41.
        a_rd[0] = 8'h00; a_rd[1] = 8'h93; a_rd[2] = 8'h41; a_nbits = 24;
        snap_a();
        run_a(8'h04, 3'd3);
        wait_a(400);
        chk("rid_done",   32'(a_donec - a_dn0), 32'd1);
        chk("rid_rises",  32'(a_rises - a_r0), 32'd33);
        chk("rid_dclow",  32'(a_dclow - a_d0), 32'd8);
        chk("rid_mosi",   32'(a_mosi_sr), 32'h04);
        chk("rid_busy",   32'(a_busyc - a_bc0), 32'd136);
        chk("rid_high",   32'(a_highc - a_h0), 32'd66);
        chk("rid_nvalid", 32'(a_vals.size() - a_v0), 32'd3);
        chk_val_a("rid_byte0", 0, 8'h00);
        chk_val_a("rid_byte1", 1, 8'h93);
        chk_val_a("rid_byte2", 2, 8'h41);
        chk("rid_cs_idle", 32'(a_cs), 32'd1);

        // Command only: cmd 0x28, no data bytes.
        a_nbits = 0;
        snap_a();
        run_a(8'h28, 3'd0);
        wait_a(200);
        chk("co_done",   32'(a_donec - a_dn0), 32'd1);
        chk("co_rises",  32'(a_rises - a_r0), 32'd8);
        chk("co_mosi",   32'(a_mosi_sr), 32'h28);
        chk("co_busy",   32'(a_busyc - a_bc0), 32'd36);
        chk("co_nvalid", 32'(a_vals.size() - a_v0), 32'd0);

        // start held high with cmd/byteCount changing every cycle.
        snap_a();
        a_cmd = 8'hA5; a_count = 3'd0; a_start = 1'b1;
        for (int i = 0; i < 200 && (a_donec - a_dn0) == 0; i++) begin
            @(posedge inClk); #1;
            a_cmd   = a_cmd + 8'h11;
            a_count = 3'd5;
        end
        chk("sb_done",   32'(a_donec - a_dn0), 32'd1);
        chk("sb_mosi",   32'(a_mosi_sr), 32'hA5);
        chk("sb_rises",  32'(a_rises - a_r0), 32'd8);
        chk("sb_busy",   32'(a_busyc - a_bc0), 32'd36);
        chk("sb_in_done_cycle", 32'(a_busy), 32'd0);
        a_cmd = 8'h6C; a_count = 3'd0;
        snap_a();
        @(posedge inClk); #1;
        chk("sb_restart", 32'(a_busy), 32'd1);
        a_start = 1'b0;
        wait_a(200);
        chk("sb2_mosi",  32'(a_mosi_sr), 32'h6C);
        chk("sb2_rises", 32'(a_rises - a_r0), 32'd8);
        chk("sb2_busy",  32'(a_busyc - a_bc0), 32'd36);

        // Reset in the middle of READ, after 12 rises.
        a_rd[0] = 8'hC3; a_rd[1] = 8'h3C; a_rd[2] = 8'hFF; a_nbits = 24;
        snap_a();
        run_a(8'h04, 3'd3);
        for (int i = 0; i < 400 && (a_rises - a_r0) < 12; i++) begin
            @(posedge inClk); #1;
        end
        chk("mr_rises", 32'(a_rises - a_r0), 32'd12);
        #2;
        nReset = 1'b0;
        #1;
        chk("mr_cs",     32'(a_cs), 32'd1);
        chk("mr_sck",    32'(a_sck), 32'd0);
        chk("mr_busy",   32'(a_busy), 32'd0);
        chk("mr_dc",     32'(a_dc), 32'd1);
        @(posedge inClk); #1;
        chk("mr_nvalid", 32'(a_vals.size() - a_v0), 32'd0);
        chk("mr_done",   32'(a_donec - a_dn0), 32'd0);
        chk("mr_data",   32'(a_data), 32'h00);
        nReset = 1'b1;
        @(posedge inClk); #1;

        // Fresh transaction after the reset.
        a_rd[0] = 8'h5A; a_nbits = 8;
        snap_a();
        run_a(8'hD3, 3'd1);
        wait_a(200);
        chk("fr_done",   32'(a_donec - a_dn0), 32'd1);
        chk("fr_rises",  32'(a_rises - a_r0), 32'd17);
        chk("fr_mosi",   32'(a_mosi_sr), 32'hD3);
        chk("fr_busy",   32'(a_busyc - a_bc0), 32'd72);
        chk("fr_nvalid", 32'(a_vals.size() - a_v0), 32'd1);
        chk_val_a("fr_byte0", 0, 8'h5A);

        // div=2: SCK toggles every inClk cycle.
        b_rd[0] = 8'hA5; b_nbits = 8;
        snap_b();
        run_b(8'h09, 3'd1);
        wait_b(200);
        chk("d2_done",   32'(b_donec - b_dn0), 32'd1);
        chk("d2_rises",  32'(b_rises - b_r0), 32'd17);
        chk("d2_high",   32'(b_highc - b_h0), 32'd17);
        chk("d2_busy",   32'(b_busyc - b_bc0), 32'd36);
        chk("d2_mosi",   32'(b_mosi_sr), 32'h09);
        chk("d2_nvalid", 32'(b_vals.size() - b_v0), 32'd1);
        chk("d2_data",   32'(b_data), 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
